// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between the fetch port and the load/store port.
// Define ARB_RR_EN for round-robin arbitration; otherwise the data port always has priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    output logic                if_stall_o,

    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_valid_o,
    output logic                dm_stall_o,

    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_e;
    typedef enum logic {GNT_IF, GNT_DM} gnt_e;

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic              drop_q, drop_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              pick_dm;

`ifdef ARB_RR_EN
    // gnt_q keeps the last grant, so on contention the other port wins.
    assign pick_dm = dm_req_i & (~if_req_i | (gnt_q == GNT_IF));
`else
    assign pick_dm = dm_req_i;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_DM;
            drop_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            drop_q      <= drop_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        drop_d      = drop_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    state_d = ISSUE;
                    drop_d  = 1'b0;
                    if (pick_dm) begin
                        gnt_d       = GNT_DM;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        mem_be_d    = dm_we_i ? dm_be_i : {BE_W{1'b1}};
                    end else begin
                        gnt_d       = GNT_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_be_d    = {BE_W{1'b1}};
                    end
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d = mem_we_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    state_d = DONE;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = mem_rdata_i;
                    end else begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flushed fetch still finishes on the memory side; only its delivery is cancelled.
        if ((state_q != IDLE) && (gnt_q == GNT_IF) && if_flush_i) begin
            drop_d = 1'b1;
        end
    end

    assign mem_en_o    = (state_q == ISSUE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    // A flush arriving in the DONE cycle itself also suppresses the wrong-path instruction.
    assign if_valid_o  = (state_q == DONE) && (gnt_q == GNT_IF) && !drop_q && !if_flush_i;
    assign dm_valid_o  = (state_q == DONE) && (gnt_q == GNT_DM);
    assign if_stall_o  = if_req_i & ~if_valid_o;
    assign dm_stall_o  = dm_req_i & ~dm_valid_o;

endmodule
